// File: rtl/remote_cmd_seq.sv
// remote_cmd_seq: FIFO-buffered {cmd,data} dispatcher for the RemoteComm handshake with ACK check and timeout.
// Optional `CMD_SEQ_RETRY_EN: one automatic resend per entry on NAK or timeout before reporting the error.
module remote_cmd_seq #(
  parameter int unsigned CMD_W       = 8,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [7:0]  ACK_VAL     = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [CMD_W-1:0]       wr_cmd,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   run,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [CMD_W-1:0]       cmd,
  output logic [DATA_W-1:0]      data,
  output logic                   send_cmd,
  input  logic                   cmd_sent,
  input  logic                   resp_rdy,
  input  logic [7:0]             resp,
  output logic                   clr_resp_rdy,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   tmo,
  output logic [7:0]             last_resp,
  output logic [7:0]             err_cnt
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = CMD_W + DATA_W;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
`ifdef CMD_SEQ_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, SEND, WAIT_SENT, WAIT_RESP, CHECK} state_t;

  state_t          state;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TW-1:0]   timer;
  logic            retried;
  logic            pop;
  logic            push;
  logic [CW-1:0]   count_nxt;
  logic            timeout_hit;
  logic            nak_hit;
  logic            fail;
  logic            retry;

  // Queue bookkeeping; a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    pop       = (state == IDLE) && run && !empty;
    push      = wr_en && (!full || pop);
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (pop && !push) count_nxt = count - CW'(1);
  end

  // Failure detection; a response arriving on the timeout cycle takes priority.
  always_comb begin
    timeout_hit = ((state == WAIT_SENT) || ((state == WAIT_RESP) && !resp_rdy)) && (timer == TMAX);
    nak_hit     = (state == CHECK) && (last_resp != ACK_VAL);
    fail        = timeout_hit || nak_hit;
    retry       = fail && RETRY_EN && !retried;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {wr_cmd, wr_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      cmd          <= '0;
      data         <= '0;
      send_cmd     <= 1'b0;
      clr_resp_rdy <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      tmo          <= 1'b0;
      last_resp    <= '0;
      err_cnt      <= '0;
      timer        <= '0;
      retried      <= 1'b0;
    end else begin
      send_cmd     <= 1'b0;
      clr_resp_rdy <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      tmo          <= 1'b0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);

      // Timer reads 0 in the send_cmd cycle and counts cycles since it.
      case (state)
        IDLE: begin
          timer <= '0;
          if (pop) begin
            {cmd, data} <= mem[rd_ptr];
            retried     <= 1'b0;
            send_cmd    <= 1'b1;
            busy        <= 1'b1;
            state       <= SEND;
          end
        end
        SEND: begin
          timer <= timer + TW'(1);
          state <= WAIT_SENT;
        end
        WAIT_SENT: begin
          if (!timeout_hit) begin
            timer <= timer + TW'(1);
            if (cmd_sent) state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (resp_rdy) begin
            last_resp    <= resp;
            clr_resp_rdy <= 1'b1;
            state        <= CHECK;
          end else if (!timeout_hit) begin
            timer <= timer + TW'(1);
          end
        end
        CHECK: begin
          if (!nak_hit) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (retry) begin
        retried  <= 1'b1;
        timer    <= '0;
        send_cmd <= 1'b1;
        state    <= SEND;
      end else if (fail) begin
        err   <= 1'b1;
        tmo   <= timeout_hit;
        busy  <= 1'b0;
        state <= IDLE;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_remote_cmd_seq.sv
// Self-checking bench for remote_cmd_seq: queue/event-level reference model, randomized traffic and responder.
module tb_remote_cmd_seq;
  localparam int DEPTH = 4;
  localparam int TMO   = 100;
  localparam logic [7:0] ACK = 8'hA5;
`ifdef CMD_SEQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, wr_en, run, cmd_sent, resp_rdy;
  logic [7:0]  wr_cmd, resp;
  logic [15:0] wr_data;
  logic        full, empty, send_cmd, clr_resp_rdy, busy, done, err, tmo;
  logic [2:0]  count;
  logic [7:0]  cmd, last_resp, err_cnt;
  logic [15:0] data;

  always #5 clk = ~clk;

  remote_cmd_seq #(.CMD_W(8), .DATA_W(16), .DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .ACK_VAL(ACK)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_data(wr_data), .run(run),
    .full(full), .empty(empty), .count(count), .cmd(cmd), .data(data), .send_cmd(send_cmd),
    .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp), .clr_resp_rdy(clr_resp_rdy),
    .busy(busy), .done(done), .err(err), .tmo(tmo), .last_resp(last_resp), .err_cnt(err_cnt));

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // ---------------- reference model (values visible after each rising edge) ----------------
  typedef struct packed {logic [7:0] c; logic [15:0] d;} ent_t;
  ent_t       mq[$];
  logic [7:0] m_cmd, m_last, m_errs;
  logic [15:0] m_data;
  bit  m_busy, m_waiting, m_sent, m_retry;
  bit  e_send, e_clr, e_done, e_err, e_tmo;
  int  m_age;
  int  cyc = 0;

  always @(posedge clk) begin : model
    bit   pop, fail, is_tmo, ns, nc, nd, ne, nt;
    ent_t ent;
    cyc++;
    ns = 0; nc = 0; nd = 0; ne = 0; nt = 0; pop = 0; fail = 0; is_tmo = 0;
    if (!rst_n) begin
      mq.delete();
      m_cmd = 0; m_data = 0; m_last = 0; m_errs = 0;
      m_busy = 0; m_waiting = 0; m_sent = 0; m_retry = 0; m_age = 0;
    end else begin
      if (!m_busy) begin
        if (run && mq.size() > 0) begin
          ent = mq.pop_front();
          m_cmd = ent.c; m_data = ent.d;
          pop = 1; m_busy = 1; m_retry = 0; ns = 1;
        end
      end else if (e_send) begin
        m_waiting = 1; m_sent = 0; m_age = 1;
      end else if (e_clr) begin
        if (m_last == ACK) begin nd = 1; m_busy = 0; end
        else fail = 1;
      end else if (m_waiting) begin
        if (m_sent && resp_rdy) begin
          m_last = resp; nc = 1; m_waiting = 0;
        end else if (m_age == TMO - 1) begin
          fail = 1; is_tmo = 1; m_waiting = 0;
        end else begin
          m_age++;
          if (cmd_sent) m_sent = 1;
        end
      end
      if (fail) begin
        if (RETRY && !m_retry) begin m_retry = 1; ns = 1; end
        else begin
          ne = 1; nt = is_tmo; m_busy = 0;
          if (m_errs != 8'hFF) m_errs = m_errs + 8'd1;
        end
      end
      if (wr_en && (mq.size() < DEPTH || pop)) begin
        ent.c = wr_cmd; ent.d = wr_data;
        mq.push_back(ent);
      end
    end
    e_send = ns; e_clr = nc; e_done = nd; e_err = ne; e_tmo = nt;
  end

  // ---------------- per-cycle compare + event log ----------------
  bit   cmp_en = 0;
  int   n_send = 0, n_done = 0, n_err = 0;
  int   t_send = 0, t_err = 0;
  bit   err_tmo = 0;
  logic [7:0]  sent_q[$];
  logic [15:0] last_data;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("send_cmd", send_cmd, e_send);
      check("clr_resp_rdy", clr_resp_rdy, e_clr);
      check("done", done, e_done);
      check("err", err, e_err);
      check("tmo", tmo, e_tmo);
      check("busy", busy, m_busy);
      check("count", count, mq.size());
      check("full", full, mq.size() == DEPTH);
      check("empty", empty, mq.size() == 0);
      check("cmd", cmd, m_cmd);
      check("data", data, m_data);
      check("last_resp", last_resp, m_last);
      check("err_cnt", err_cnt, m_errs);
      if (send_cmd) begin n_send++; t_send = cyc; sent_q.push_back(cmd); last_data = data; end
      if (done) n_done++;
      if (err) begin n_err++; t_err = cyc; err_tmo = tmo; end
    end
  end

  // ---------------- RemoteComm responder ----------------
  // mode: 0 ACK, 1 NAK 8'hFF, 2 cmd_sent but never a response, 3 random per transaction
  int mode = 0;
  int r_st = 0, r_dly = 0, r_kind = 0;
  logic [7:0] r_val;

  always @(negedge clk) begin
    if (!rst_n) begin
      r_st = 0; cmd_sent = 0; resp_rdy = 0; resp = 0;
    end else begin
      case (r_st)
        0: if (send_cmd) begin
             r_dly = $urandom_range(0, 3);
             r_kind = mode;
             if (mode == 3) r_kind = ($urandom_range(0, 9) < 6) ? 0 : (($urandom_range(0, 3) == 0) ? 2 : 1);
             r_val = (r_kind == 0) ? ACK : ((mode == 3) ? 8'($urandom_range(0, 255)) : 8'hFF);
             r_st = 1;
           end
        1: if (r_dly == 0) begin cmd_sent = 1; r_st = 2; end else r_dly--;
        2: begin
             cmd_sent = 0;
             r_dly = $urandom_range(0, 3);
             r_st = (r_kind == 2) ? 0 : 3;
           end
        3: if (r_dly == 0) begin resp_rdy = 1; resp = r_val; r_st = 4; end else r_dly--;
        default: if (clr_resp_rdy) begin resp_rdy = 0; r_st = 0; end
      endcase
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic push(input logic [7:0] c, input logic [15:0] d);
    wr_en = 1; wr_cmd = c; wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic wait_done(input string name, input int target, input int bound);
    int i = 0;
    while (n_done < target && i < bound) begin tick(); i++; end
    check(name, n_done >= target, 1);
  endtask

  task automatic wait_err(input string name, input int target, input int bound);
    int i = 0;
    while (n_err < target && i < bound) begin tick(); i++; end
    check(name, n_err >= target, 1);
  endtask

  initial begin
    int s0, d0, e0, base, i;
    rst_n = 0; wr_en = 0; run = 0; wr_cmd = 0; wr_data = 0;
    repeat (3) tick();
    cmp_en = 1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_err_cnt", err_cnt, 0);
    rst_n = 1;

    // single ACKed command
    mode = 0; d0 = n_done; base = sent_q.size();
    push(8'h06, 16'h0000);
    run = 1;
    wait_done("t1_done", d0 + 1, 50);
    check("t1_cmd", sent_q[base], 8'h06);
    check("t1_err_cnt", err_cnt, 0);
    tick();
    check("t1_empty", empty, 1);

    // NAK
    mode = 1; s0 = n_send; e0 = n_err;
    push(8'h09, 16'h8991);
    wait_err("t2_err", e0 + 1, 300);
    check("t2_last_resp", last_resp, 8'hFF);
    check("t2_tmo", err_tmo, 0);
    check("t2_err_cnt", err_cnt, 1);
    check("t2_data", last_data, 16'h8991);
    check("t2_sends", n_send - s0, RETRY ? 2 : 1);

    // timeout: no response at all
    mode = 2;
    push(8'h33, 16'h1234);
    wait_err("t3_err", e0 + 2, 500);
    check("t3_latency", t_err - t_send, 100);
    check("t3_tmo", err_tmo, 1);
    check("t3_err_cnt", err_cnt, 2);
    tick();
    check("t3_idle", busy, 0);

    // overflow drop, then in-order drain
    run = 0; mode = 0;
    for (int k = 0; k < 5; k++) push(8'h40 + 8'(k), 16'(k));
    check("t4_full", full, 1);
    check("t4_count", count, 4);
    base = sent_q.size(); d0 = n_done;
    run = 1;
    wait_done("t4_done", d0 + 4, 200);
    repeat (10) tick();
    check("t4_nsent", sent_q.size() - base, 4);
    for (int k = 0; k < 4; k++) check("t4_order", sent_q[base + k], 8'h40 + 8'(k));

    // push while full accepted because of a same-cycle pop
    run = 0;
    for (int k = 0; k < 4; k++) push(8'h50 + 8'(k), 16'h5000);
    check("t5_full", full, 1);
    d0 = n_done; base = sent_q.size();
    run = 1; wr_en = 1; wr_cmd = 8'h5F; wr_data = 16'h5F5F;
    tick();
    wr_en = 0;
    check("t5_count", count, 4);
    wait_done("t5_done", d0 + 5, 300);
    check("t5_last", sent_q[base + 4], 8'h5F);

    // reset in WAIT_RESP with two entries queued
    run = 0; mode = 2;
    for (int k = 0; k < 3; k++) push(8'h70 + 8'(k), 16'h7000);
    run = 1;
    tick();
    run = 0;
    repeat (8) tick();
    check("t6_busy_pre", busy, 1);
    check("t6_count_pre", count, 2);
    rst_n = 0;
    tick();
    check("t6_busy", busy, 0);
    check("t6_empty", empty, 1);
    check("t6_count", count, 0);
    check("t6_err_cnt", err_cnt, 0);
    rst_n = 1; run = 1; s0 = n_send;
    repeat (10) tick();
    check("t6_no_send", n_send, s0);

    // randomized traffic
    mode = 3;
    for (int k = 0; k < 3000; k++) begin
      wr_en = ($urandom_range(0, 2) == 0);
      wr_cmd = 8'($urandom);
      wr_data = 16'($urandom);
      if ($urandom_range(0, 24) == 0) run = !run;
      rst_n = ($urandom_range(0, 1499) != 0);
      tick();
    end
    wr_en = 0; rst_n = 1; run = 1;
    i = 0;
    while (!(empty && !busy) && i < 3000) begin tick(); i++; end
    check("drain", empty && !busy, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
